// File: rtl/seg_scanner.sv
// seg_scanner: bus-programmable multiplexed 7-segment driver.
// Raw mode drives the RAW register straight to the pins. Scan mode steps
// through the digit buffer, one digit per PRESCALE clocks, and blanks the
// first DEAD clocks of every slot to avoid ghosting.
//
// Bus handshake: a cycle is requested while CYC_I and STB_I are both high.
// The block answers with a single-cycle ACK_O on the next edge. That same
// edge commits a write and registers read data. ACK_O toggles low after
// every acknowledge, so a strobe held high is answered on alternate cycles.
// DAT_O is zero whenever ACK_O is low.
module seg_scanner #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int DEAD     = 8
) (
    input  logic              CLK_I,
    input  logic              RES_I,
    input  logic [2:0]        ADR_I,
    input  logic              WE_I,
    input  logic              CYC_I,
    input  logic              STB_I,
    input  logic [1:0]        SEL_I,
    input  logic [15:0]       DAT_I,
    output logic [15:0]       DAT_O,
    output logic              ACK_O,
    output logic [7:0]        SEG_O,
    output logic [DIGITS-1:0] AN_O
);

    localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   P_LAST   = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]   P_DEAD   = PW'(DEAD);
    localparam logic [2:0]      IDX_LAST = 3'(DIGITS - 1);

    // Control and display state
    logic              r_mode;
    logic              r_blank;
    logic [7:0]        r_raw_seg;
    logic [DIGITS-1:0] r_raw_an;
    // Eight slots so any address decodes; slots at or above DIGITS stay zero
    logic [7:0]        r_buf [0:7];
    logic [PW-1:0]     r_presc;
    logic [2:0]        r_idx;
    logic              r_ack;
    logic [15:0]       r_dat;
    logic [7:0]        r_seg;
    logic [DIGITS-1:0] r_an;

    logic              w_acc;
    logic              w_wr;
    logic              w_mode_chg;
    logic              w_dead;
    logic [15:0]       w_rdata;
    logic [DIGITS-1:0] w_an_onehot;

    assign w_acc       = ~r_ack & CYC_I & STB_I;
    assign w_wr        = w_acc & WE_I;
    // Only a CTRL write that actually flips MODE restarts the scan
    assign w_mode_chg  = w_wr & (ADR_I == 3'd0) & SEL_I[0] & (DAT_I[0] != r_mode);
    assign w_dead      = r_mode & (r_presc < P_DEAD);
    assign w_an_onehot = DIGITS'(1) << r_idx;

    assign ACK_O = r_ack;
    assign DAT_O = r_dat;
    assign SEG_O = r_seg;
    assign AN_O  = r_an;

    // Read-data decode from the current (pre-edge) register contents
    always_comb begin
        w_rdata = '0;
        case (ADR_I)
            3'd0: w_rdata[1:0] = {r_blank, r_mode};
            3'd1: begin
                w_rdata[7:0]        = r_raw_seg;
                w_rdata[8 +: DIGITS] = r_raw_an;
            end
            3'd2: w_rdata[3:0] = {w_dead, r_idx};
            3'd4, 3'd5, 3'd6, 3'd7:
                w_rdata = {r_buf[{ADR_I[1:0], 1'b1}], r_buf[{ADR_I[1:0], 1'b0}]};
            default: w_rdata = '0;
        endcase
    end

    // Bus acknowledge, read data and register writes; reset drops any cycle
    always_ff @(posedge CLK_I) begin
        if (RES_I) begin
            r_ack     <= 1'b0;
            r_dat     <= '0;
            r_mode    <= 1'b0;
            r_blank   <= 1'b0;
            r_raw_seg <= 8'hFF;
            r_raw_an  <= '1;
            for (int d = 0; d < 8; d++) r_buf[d] <= 8'h00;
        end else begin
            r_ack <= w_acc;
            r_dat <= (w_acc & ~WE_I) ? w_rdata : 16'h0000;
            if (w_wr) begin
                case (ADR_I)
                    3'd0: begin
                        if (SEL_I[0]) begin
                            r_mode  <= DAT_I[0];
                            r_blank <= DAT_I[1];
                        end
                    end
                    3'd1: begin
                        if (SEL_I[0]) r_raw_seg <= DAT_I[7:0];
                        if (SEL_I[1]) r_raw_an  <= DAT_I[8 +: DIGITS];
                    end
                    3'd4, 3'd5, 3'd6, 3'd7: begin
                        for (int d = 0; d < DIGITS; d++) begin
                            if (d / 2 == int'(ADR_I[1:0])) begin
                                if (d % 2 == 0) begin
                                    if (SEL_I[0]) r_buf[d] <= DAT_I[7:0];
                                end else begin
                                    if (SEL_I[1]) r_buf[d] <= DAT_I[15:8];
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Slot prescaler and digit index; held at zero in raw mode
    always_ff @(posedge CLK_I) begin
        if (RES_I || w_mode_chg || !r_mode) begin
            r_presc <= '0;
            r_idx   <= 3'd0;
        end else if (r_presc == P_LAST) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Registered pin drive: lamp test on reset, then blank/raw/scan selection
    always_ff @(posedge CLK_I) begin
        if (RES_I) begin
            r_seg <= 8'hFF;
            r_an  <= '1;
        end else if (r_blank) begin
            r_seg <= 8'h00;
            r_an  <= '0;
        end else if (!r_mode) begin
            r_seg <= r_raw_seg;
            r_an  <= r_raw_an;
        end else if (w_dead) begin
            r_seg <= 8'h00;
            r_an  <= '0;
        end else begin
            r_seg <= r_buf[r_idx];
            r_an  <= w_an_onehot;
        end
    end

endmodule

// File: tb/tb_seg_scanner.sv
// tb_seg_scanner: directed tables, hand sequences and randomized bus traffic
// for seg_scanner, checked against a time-based model of the display.
module tb_seg_scanner;

    localparam int D  = 4;
    localparam int P  = 16;
    localparam int DT = 2;

    // ---------------- clock / shared bus signals ----------------
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        res;
    logic [2:0]  adr;
    logic        we;
    logic        stb;
    logic [1:0]  sel;
    logic [15:0] dat_i;
    logic        cyc_a;
    logic        cyc_b;

    logic [15:0] dat_a, dat_b;
    logic        ack_a, ack_b;
    logic [7:0]  seg_a, seg_b;
    logic [3:0]  an_a;
    logic [0:0]  an_b;

    seg_scanner #(.DIGITS(4), .PRESCALE(16), .DEAD(2)) u_a (
        .CLK_I(clk), .RES_I(res), .ADR_I(adr), .WE_I(we), .CYC_I(cyc_a),
        .STB_I(stb), .SEL_I(sel), .DAT_I(dat_i), .DAT_O(dat_a), .ACK_O(ack_a),
        .SEG_O(seg_a), .AN_O(an_a)
    );

    seg_scanner #(.DIGITS(1), .PRESCALE(2), .DEAD(1)) u_b (
        .CLK_I(clk), .RES_I(res), .ADR_I(adr), .WE_I(we), .CYC_I(cyc_b),
        .STB_I(stb), .SEL_I(sel), .DAT_I(dat_i), .DAT_O(dat_b), .ACK_O(ack_b),
        .SEG_O(seg_b), .AN_O(an_b)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Display A: m_t counts clocks since the scan (re)started; slot phase and
    // digit follow from plain division of that time.
    bit          m_mode, m_blank, m_chk;
    logic [7:0]  m_raw_seg;
    logic [3:0]  m_raw_an;
    logic [7:0]  m_buf [4];
    int          m_t;
    // Display B (1 digit, 2-clock slot): lit on every second clock
    bit          b_mode, b_chk;
    logic [7:0]  b_buf0;
    int          b_t;
    // Write that the next edge will commit
    bit          pw_valid, pw_b;
    logic [2:0]  pw_adr;
    logic [1:0]  pw_sel;
    logic [15:0] pw_dat;

    function automatic logic [15:0] model_read(input logic [2:0] a);
        int ph, dg, k;
        ph = m_t % P;
        dg = (m_t / P) % D;
        k  = int'(a) - 4;
        case (a)
            3'd0: return {14'd0, m_blank, m_mode};
            3'd1: return {4'd0, m_raw_an, m_raw_seg};
            3'd2: return {12'd0, (m_mode && ph < DT), 3'(dg)};
            3'd4, 3'd5: return {m_buf[2*k+1], m_buf[2*k]};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic void model_out(output logic [7:0] s, output logic [3:0] an);
        int ph, dg;
        ph = m_t % P;
        dg = (m_t / P) % D;
        if (m_blank) begin s = 8'h00; an = 4'h0; end
        else if (!m_mode) begin s = m_raw_seg; an = m_raw_an; end
        else if (ph < DT) begin s = 8'h00; an = 4'h0; end
        else begin s = m_buf[dg]; an = 4'b0001 << dg; end
    endfunction

    task automatic model_reset();
        m_mode = 0; m_blank = 0; m_raw_seg = 8'hFF; m_raw_an = 4'hF; m_t = 0;
        for (int i = 0; i < 4; i++) m_buf[i] = 8'h00;
        b_mode = 0; b_chk = 0; b_t = 0; b_buf0 = 8'h00;
    endtask

    task automatic model_write(input logic [2:0] a, input logic [1:0] s,
                               input logic [15:0] d, output bit chg);
        int k;
        chg = 0;
        k = int'(a) - 4;
        case (a)
            3'd0: if (s[0]) begin chg = (d[0] != m_mode); m_mode = d[0]; m_blank = d[1]; end
            3'd1: begin
                if (s[0]) m_raw_seg = d[7:0];
                if (s[1]) m_raw_an  = d[11:8];
            end
            3'd4, 3'd5, 3'd6, 3'd7: begin
                if (s[0] && 2*k < D)   m_buf[2*k]   = d[7:0];
                if (s[1] && 2*k+1 < D) m_buf[2*k+1] = d[15:8];
            end
            default: ;
        endcase
    endtask

    // One clock: predict pins from pre-edge model, sample after edge, advance model
    task automatic tick();
        logic [7:0] es, bes;
        logic [3:0] ea;
        logic       ban;
        bit         r_pre, mode_pre, chg, bchg;
        r_pre = res;
        if (r_pre) begin es = 8'hFF; ea = 4'hF; end
        else model_out(es, ea);
        ban = (b_t % 2 == 1);
        bes = ban ? b_buf0 : 8'h00;
        mode_pre = m_mode;
        @(posedge clk); #1;
        if (m_chk) begin
            check("seg_a", seg_a, es);
            check("an_a", an_a, ea);
        end
        if (b_chk && !r_pre) begin
            check("seg_b", seg_b, bes);
            check("an_b", an_b, ban);
        end
        if (r_pre) begin
            model_reset();
            m_chk = 1;
        end else begin
            chg = 0;
            bchg = 0;
            if (pw_valid && !pw_b) model_write(pw_adr, pw_sel, pw_dat, chg);
            if (chg) m_t = 0;
            else if (mode_pre) m_t++;
            else m_t = 0;
            if (pw_valid && pw_b) begin
                if (pw_adr == 3'd0 && pw_sel[0] && pw_dat[0] != b_mode) bchg = 1;
                if (pw_adr == 3'd4 && pw_sel[0]) b_buf0 = pw_dat[7:0];
            end
            if (bchg) begin b_mode = pw_dat[0]; b_chk = b_mode; b_t = 0; end
            else if (b_chk) b_t++;
        end
        pw_valid = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_write(input bit to_b, input logic [2:0] a, input logic [1:0] s,
                             input logic [15:0] d);
        adr = a; sel = s; dat_i = d; we = 1; stb = 1;
        if (to_b) cyc_b = 1; else cyc_a = 1;
        pw_valid = 1; pw_b = to_b; pw_adr = a; pw_sel = s; pw_dat = d;
        tick();
        check("wr_ack", to_b ? ack_b : ack_a, 1);
        cyc_a = 0; cyc_b = 0; stb = 0; we = 0;
        tick();
        check("wr_ack_drop", to_b ? ack_b : ack_a, 0);
    endtask

    task automatic bus_read(input bit to_b, input logic [2:0] a, output logic [15:0] d);
        adr = a; sel = 2'b11; we = 0; stb = 1;
        if (to_b) cyc_b = 1; else cyc_a = 1;
        tick();
        check("rd_ack", to_b ? ack_b : ack_a, 1);
        d = to_b ? dat_b : dat_a;
        cyc_a = 0; cyc_b = 0; stb = 0;
        tick();
        check("rd_ack_drop", to_b ? ack_b : ack_a, 0);
        check("rd_dat_idle", to_b ? dat_b : dat_a, 0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [2:0]  adr;
        logic [1:0]  sel;
        logic [15:0] wdat;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [11];

    // ---------------- main test ----------------
    initial begin
        logic [15:0] rd, e;
        int cnt0, cnt1, cnt2, cnt3, cnt4, guard, op, lit;
        logic [2:0] ra;
        bit nm, nb;

        tbl[0]  = '{3'd1, 2'b11, 16'h0A5B, 16'h0A5B};
        tbl[1]  = '{3'd1, 2'b01, 16'hFFFF, 16'h0AFF};
        tbl[2]  = '{3'd1, 2'b10, 16'hF3C3, 16'h03FF};
        tbl[3]  = '{3'd3, 2'b11, 16'hFFFF, 16'h0000};
        tbl[4]  = '{3'd4, 2'b11, 16'h3F06, 16'h3F06};
        tbl[5]  = '{3'd5, 2'b11, 16'h5B4F, 16'h5B4F};
        tbl[6]  = '{3'd6, 2'b11, 16'h1234, 16'h0000};
        tbl[7]  = '{3'd7, 2'b11, 16'hABCD, 16'h0000};
        tbl[8]  = '{3'd2, 2'b11, 16'hFFFF, 16'h0000};
        tbl[9]  = '{3'd0, 2'b10, 16'hFFFF, 16'h0000};
        tbl[10] = '{3'd1, 2'b11, 16'h0A5B, 16'h0A5B};

        res = 1; adr = 0; we = 0; stb = 0; sel = 0; dat_i = 0; cyc_a = 0; cyc_b = 0;
        pw_valid = 0; m_chk = 0; b_chk = 0; b_t = 0; m_t = 0;
        repeat (2) tick();
        check("rst_ack", ack_a, 0);
        check("rst_seg", seg_a, 8'hFF);
        check("rst_an", an_a, 4'hF);
        res = 0;
        tick();
        bus_read(0, 3'd0, rd); check("rst_ctrl", rd, 16'h0000);
        bus_read(0, 3'd1, rd); check("rst_raw", rd, 16'h0FFF);

        // held strobe is answered on alternate cycles
        adr = 3'd0; we = 0; stb = 1; cyc_a = 1;
        tick(); check("b2b_ack0", ack_a, 1);
        tick(); check("b2b_ack1", ack_a, 0);
        tick(); check("b2b_ack2", ack_a, 1);
        tick(); check("b2b_ack3", ack_a, 0);
        cyc_a = 0; stb = 0;
        tick(); check("b2b_idle", ack_a, 0);

        // register write / readback table (raw mode)
        for (int i = 0; i < 11; i++) begin
            bus_write(0, tbl[i].adr, tbl[i].sel, tbl[i].wdat);
            bus_read(0, tbl[i].adr, rd);
            check($sformatf("tbl%0d", i), rd, tbl[i].exp);
        end
        check("raw_seg", seg_a, 8'h5B);
        check("raw_an", an_a, 4'b1010);

        // scan: one full 64-clock period tallied per digit
        bus_write(0, 3'd0, 2'b11, 16'h0001);
        cnt0 = 0; cnt1 = 0; cnt2 = 0; cnt3 = 0; cnt4 = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (an_a == 4'b0000 && seg_a == 8'h00) cnt0++;
            if (an_a == 4'b0001 && seg_a == 8'h06) cnt1++;
            if (an_a == 4'b0010 && seg_a == 8'h3F) cnt2++;
            if (an_a == 4'b0100 && seg_a == 8'h4F) cnt3++;
            if (an_a == 4'b1000 && seg_a == 8'h5B) cnt4++;
        end
        check("scan_dead_cnt", cnt0, 8);
        check("scan_d0_cnt", cnt1, 14);
        check("scan_d1_cnt", cnt2, 14);
        check("scan_d2_cnt", cnt3, 14);
        check("scan_d3_cnt", cnt4, 14);

        // STATUS index follows the slots
        for (int s = 0; s < 4; s++) begin
            guard = 0;
            while ((m_t % P) != 8 && guard < 100) begin tick(); guard++; end
            check("status_wait", guard < 100, 1);
            bus_read(0, 3'd2, rd);
            check($sformatf("status_slot%0d", s), rd, 16'((m_t / P) % D));
        end

        // STATUS read on the wrap edge returns the old index
        guard = 0;
        while ((m_t % P) != P - 1 && guard < 100) begin tick(); guard++; end
        check("wrap_wait", guard < 100, 1);
        e = model_read(3'd2);
        bus_read(0, 3'd2, rd);
        check("wrap_status", rd, e);

        // live update of the lit digit
        guard = 0;
        while (!((m_t % P) == 5 && ((m_t / P) % D) == 0) && guard < 100) begin tick(); guard++; end
        check("lit_wait", guard < 100, 1);
        bus_write(0, 3'd4, 2'b01, 16'h0077);
        check("live_seg", seg_a, 8'h77);
        check("live_an", an_a, 4'b0001);

        // blank keeps scanning, unblank resumes without restart
        bus_write(0, 3'd0, 2'b11, 16'h0003);
        e = model_read(3'd2);
        bus_read(0, 3'd2, rd); check("blank_status0", rd, e);
        lit = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (an_a != 0) lit++; end
        check("blank_dark", lit, 0);
        e = model_read(3'd2);
        bus_read(0, 3'd2, rd); check("blank_status1", rd, e);
        bus_write(0, 3'd0, 2'b11, 16'h0001);
        repeat (20) tick();

        // reset mid-scan alongside a write: dropped, lamp test
        adr = 3'd5; sel = 2'b11; dat_i = 16'h1234; we = 1; stb = 1; cyc_a = 1; res = 1;
        tick();
        check("rst_wr_ack", ack_a, 0);
        res = 0; cyc_a = 0; stb = 0; we = 0;
        tick();
        check("rst_wr_ack2", ack_a, 0);
        check("rst_lamp_seg", seg_a, 8'hFF);
        check("rst_lamp_an", an_a, 4'hF);
        bus_read(0, 3'd5, rd); check("rst_buf5", rd, 16'h0000);

        // single digit, two-clock slots
        bus_write(1, 3'd0, 2'b11, 16'h0001);
        lit = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (an_b == 1'b1) lit++; end
        check("b_lit_cnt", lit, 3);
        bus_write(1, 3'd4, 2'b10, 16'hAB00);
        bus_read(1, 3'd4, rd); check("b_hi_ignored", rd, 16'h0000);
        bus_write(1, 3'd4, 2'b01, 16'h00C4);
        bus_read(1, 3'd4, rd); check("b_lo_written", rd, 16'h00C4);
        repeat (4) tick();

        // randomized traffic on display A in scan mode
        bus_write(0, 3'd0, 2'b11, 16'h0001);
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                repeat ($urandom_range(1, 6)) tick();
            end else if (op <= 5) begin
                bus_write(0, 3'($urandom_range(4, 7)), 2'($urandom_range(1, 3)), 16'($urandom));
            end else if (op <= 7) begin
                ra = 3'($urandom_range(0, 7));
                e = model_read(ra);
                bus_read(0, ra, rd);
                check("rnd_read", rd, e);
            end else if (op == 8) begin
                nm = ($urandom_range(0, 11) == 0) ? ~m_mode : m_mode;
                nb = ($urandom_range(0, 3) == 0);
                bus_write(0, 3'd0, 2'($urandom_range(1, 3)), {14'd0, nb, nm});
            end else begin
                bus_write(0, 3'd1, 2'($urandom_range(1, 3)), 16'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seg_scanner.md
SEG_SCANNER -- requirements
Module: seg_scanner

Interface
REQ-001 The block SHALL be parameterised as follows:
- DIGITS, default 4: number of digits, legal range 1..8.
- PRESCALE, default 50000: clocks per digit slot, minimum 2.
- DEAD, default 8: blanking clocks at the start of each slot, must be less than PRESCALE.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with the ports listed below (clock and reset first):
- CLK_I  in  1  system clock.
- RES_I  in  1  synchronous active-high reset.
- ADR_I  in  3  word address, 16-bit words.
- WE_I  in  1  write enable.
- CYC_I  in  1  bus cycle.
- STB_I  in  1  strobe, already address-decoded.
- SEL_I  in  2  byte lanes: [0] selects bits 7:0, [1] selects bits 15:8.
- DAT_I  in  16  write data.
- DAT_O  out  16  read data.
- ACK_O  out  1  cycle acknowledge.
- SEG_O  out  8  segment drive a..g,dp in bits 0..7, active high.
- AN_O  out  DIGITS  digit anode enables, active high.

Function
REQ-003 The register map SHALL be:
- 0 CTRL: bit0 MODE (0 raw, 1 scan), bit1 BLANK, other bits read 0.
- 1 RAW: [7:0] segments, [8+DIGITS-1:8] anodes.
- 2 STATUS, read-only: [2:0] current digit index, [3] dead-time active.
- 3: reads 0.
- 4..7 digit buffer: word k holds digit 2(k-4) in [7:0] and digit 2(k-4)+1 in [15:8].
REQ-004 Writes SHALL affect only the byte lanes whose SEL_I bit is set.
REQ-005 Writes to RAW bits above the anode width, to STATUS, to address 3, or to digits >= DIGITS SHALL be ignored; those bits SHALL read 0.
REQ-006 ACK_O SHALL be registered: ACK_O <= ~ACK_O & CYC_I & STB_I. This gives exactly one-cycle latency, and back-to-back strobes are acknowledged on alternate cycles.
REQ-007 A write SHALL take effect on the clock edge that asserts ACK_O.
REQ-008 DAT_O SHALL be registered on the same edge that asserts ACK_O and SHALL be 0 when ACK_O is low.
REQ-009 Raw mode (MODE=0): SEG_O and AN_O SHALL equal the RAW fields, registered, updating one clock after the RAW write edge.
REQ-010 Scan mode (MODE=1): a prescaler SHALL count 0..PRESCALE-1 and wrap. When it wraps, the digit index SHALL advance, and SHALL wrap from DIGITS-1 to 0.
REQ-011 When DIGITS=1, the index SHALL stay at 0.
REQ-012 During prescaler counts 0..DEAD-1 of each slot, SEG_O and AN_O SHALL be 0 (dead time) and STATUS[3] SHALL be 1.
REQ-013 During prescaler counts DEAD..PRESCALE-1 of each slot:
- SEG_O SHALL be buffer[index].
- AN_O SHALL be one-hot at the index.
- Both SHALL be registered.
REQ-014 A buffer write to the currently displayed digit SHALL appear on SEG_O on the clock after the write edge, with no wait for the next slot.
REQ-015 Any write to CTRL that changes MODE SHALL clear both the prescaler and the index to 0, so the first scan slot starts with dead time at digit 0.
REQ-016 A CTRL write that does not change MODE SHALL leave the prescaler and index untouched.
REQ-017 BLANK=1 SHALL force SEG_O and AN_O to 0 in both modes, from the clock after the write edge. The prescaler and index SHALL keep running while blanked.
REQ-018 In raw mode, the prescaler and index SHALL be held at 0.
REQ-019 A bus access coinciding with a prescaler wrap SHALL complete normally. A STATUS read on that edge SHALL return the pre-advance index.

Reset
REQ-020 RES_I SHALL take priority over all bus activity. When it is asserted, the following SHALL hold on the next edge:
- CTRL = 0 (raw mode, unblanked).
- RAW segments = 0xFF and RAW anodes = all 1 (lamp test).
- Digit buffer = 0x00.
- Prescaler = 0 and index = 0.
- ACK_O = 0 and DAT_O = 0.
- SEG_O = 0xFF and AN_O = all 1 from the first clock after reset.
REQ-021 A bus cycle in progress when RES_I asserts SHALL be dropped: its write SHALL NOT be committed and no ACK_O SHALL be issued.

Verification
REQ-022 The bench SHALL cover these directed scenarios (DIGITS=4, PRESCALE=16, DEAD=2 unless stated):
- Reset -> SEG_O=0xFF, AN_O=4'b1111, ACK_O=0. Read CTRL -> 0x0000. Read RAW -> 0x0FFF.
- Write RAW=0x0A5B, SEL=2'b11 -> ACK_O high exactly one cycle. The next clock gives SEG_O=0x5B, AN_O=4'b1010. Then write 0xFFFF with SEL=2'b01 only -> RAW reads 0x0AFF.
- Buffer = 0x3F06 at address 4 and 0x5B4F at address 5. Write CTRL=1 -> repeating 64-clock cycle:
  - AN_O = 0 for 2 clocks, then 0001 with SEG_O=0x06 for 14 clocks;
  - then 0010/0x3F, 0100/0x4F, 1000/0x5B;
  - STATUS[2:0] tracks 0,1,2,3.
- Write buffer address 4 while digit 0 is lit -> SEG_O changes on the next clock. Write CTRL=3 -> AN_O=0 while STATUS keeps advancing. Write CTRL=1 -> display resumes without an index reset.
- Assert RES_I mid-scan, coincident with a bus write to address 5 -> no ACK_O. Buffer address 5 reads 0. Outputs return to lamp test.
- DIGITS=1, PRESCALE=2, DEAD=1, scan mode -> AN_O alternates 0,1 every clock. Write to address 4 with SEL=2'b10 is ignored and reads back 0 in [15:8].
